// File: rtl/spi_rr_arbiter.sv
// Purpose : round-robin arbiter/sequencer sharing one SPI byte engine between NREQ requesters.
// Latency : req -> grant 1 cycle, -> eng_start/ss_n low 2 cycles; eng_done -> rx_valid 1 cycle.
// Backpr. : WAIT stalls until eng_done; optional watchdog (define SPI_ARB_TIMEOUT_EN) aborts after TIMEOUT cycles.
module spi_rr_arbiter #(
    parameter int NREQ    = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic [NREQ*8-1:0]     req_tx_data,
    output logic [NREQ-1:0]       grant,
    output logic                  tx_pop,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    output logic [NREQ-1:0]       txn_done,
    output logic                  busy,
    output logic                  ss_n,
    output logic                  eng_start,
    output logic [7:0]            eng_tx_data,
    input  logic                  eng_done,
    input  logic [7:0]            eng_rx_data,
    output logic                  timeout_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Elaboration-time guard on the supported configuration range.
    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("spi_rr_arbiter: unsupported parameter value");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_RELEASE} state_t;

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              tx_pop_q, tx_pop_d;
    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic [NREQ-1:0]   txn_done_q, txn_done_d;
    logic              busy_q, busy_d;
    logic              ss_n_q, ss_n_d;
    logic              eng_start_q, eng_start_d;
    logic [7:0]        eng_tx_data_q, eng_tx_data_d;

    logic              pick_vld;
    logic [PW-1:0]     pick_idx;
    logic [LEN_W-1:0]  pick_len;
    logic [7:0]        owner_tx;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    // Round-robin pick: first requester strictly after the pointer, wrapping; the last owner goes last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!pick_vld && req[(int'(rr_ptr_q) + i) % NREQ]) begin
                pick_vld = 1'b1;
                pick_idx = PW'((int'(rr_ptr_q) + i) % NREQ);
            end
        end
        pick_len = req_len[int'(pick_idx)*LEN_W +: LEN_W];
        owner_tx = req_tx_data[int'(owner_q)*8 +: 8];
    end

    // Sequencer next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        remaining_d   = remaining_q;
        tx_pop_d      = 1'b0;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        txn_done_d    = '0;
        busy_d        = busy_q;
        ss_n_d        = ss_n_q;
        eng_start_d   = 1'b0;
        eng_tx_data_d = eng_tx_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
        tmo_d         = tmo_q;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    grant_d     = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d     = pick_idx;
                    busy_d      = 1'b1;
                    // A zero length still moves one byte.
                    remaining_d = (pick_len == '0) ? LEN_W'(1) : pick_len;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                eng_start_d   = 1'b1;
                eng_tx_data_d = owner_tx;
                tx_pop_d      = 1'b1;
                ss_n_d        = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
                tmo_d         = '0;
`endif
                state_d       = S_WAIT;
            end
            S_WAIT: begin
                if (eng_done) begin
                    rx_data_d   = eng_rx_data;
                    rx_valid_d  = 1'b1;
                    remaining_d = remaining_q - LEN_W'(1);
                    state_d     = (remaining_q == LEN_W'(1)) ? S_RELEASE : S_LOAD;
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_RELEASE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            S_RELEASE: begin
                ss_n_d     = 1'b1;
                txn_done_d = grant_q;
                rr_ptr_d   = owner_q;
                grant_d    = '0;
                busy_d     = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; synchronous reset returns everything to idle values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            grant_q       <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= PW'(NREQ - 1);
            remaining_q   <= '0;
            tx_pop_q      <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            txn_done_q    <= '0;
            busy_q        <= 1'b0;
            ss_n_q        <= 1'b1;
            eng_start_q   <= 1'b0;
            eng_tx_data_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            remaining_q   <= remaining_d;
            tx_pop_q      <= tx_pop_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            txn_done_q    <= txn_done_d;
            busy_q        <= busy_d;
            ss_n_q        <= ss_n_d;
            eng_start_q   <= eng_start_d;
            eng_tx_data_q <= eng_tx_data_d;
`ifdef SPI_ARB_TIMEOUT_EN
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign tx_pop      = tx_pop_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign txn_done    = txn_done_q;
    assign busy        = busy_q;
    assign ss_n        = ss_n_q;
    assign eng_start   = eng_start_q;
    assign eng_tx_data = eng_tx_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
